// File: rtl/iteration_vector_counter_if.sv
// Control and iteration-vector bus between the loop-nest walker and the global controller.
// Vectors are big-endian packed: element j lives in bits [j*MATRIX_ELEMENT_WIDTH +: MATRIX_ELEMENT_WIDTH].
interface iteration_vector_counter_if #(
  parameter int DIMENSION            = 3,
  parameter int MATRIX_ELEMENT_WIDTH = 8
);
  logic                                       start;
  logic [0:DIMENSION*MATRIX_ELEMENT_WIDTH-1]  bounds;
  logic                                       stall;
  logic [0:DIMENSION*MATRIX_ELEMENT_WIDTH-1]  iter_vec;
  logic [0:DIMENSION-1]                       last_flags;
  logic                                       iter_valid;
  logic                                       busy;
  logic                                       done;

  modport master (
    output start, bounds, stall,
    input  iter_vec, last_flags, iter_valid, busy, done
  );

  modport slave (
    input  start, bounds, stall,
    output iter_vec, last_flags, iter_valid, busy, done
  );
endinterface

// File: rtl/iteration_vector_counter.sv
// Walks a DIMENSION-deep loop nest (element 0 innermost) and emits one registered
// iteration vector per non-stalled cycle, with per-element "last" flags.
module iteration_vector_counter #(
  parameter int DIMENSION            = 3,
  parameter int MATRIX_ELEMENT_WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  iteration_vector_counter_if.slave bus
);
  localparam int W  = MATRIX_ELEMENT_WIDTH;
  localparam int VW = DIMENSION * MATRIX_ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [0:VW-1]        bounds_q;
  logic [0:VW-1]        iter_q, iter_d;
  logic [0:DIMENSION-1] last_q, last_d;
  logic [0:DIMENSION-1] start_last;
  logic                 valid_q, busy_q, done_q;
  logic                 zero_trip;
  logic                 carry;
  logic                 final_vec;

  function automatic logic [W-1:0] elem(input logic [0:VW-1] v, input int j);
    return v[j*W +: W];
  endfunction

  // Mixed-radix increment: an element wraps exactly when its last flag is set,
  // since last_q always describes iter_q.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    iter_d     = iter_q;
    last_d     = '0;
    start_last = '0;
    zero_trip  = 1'b0;
    carry      = 1'b1;
    for (int j = 0; j < DIMENSION; j++) begin
      if (carry) begin
        if (last_q[j]) begin
          iter_d[j*W +: W] = '0;
        end else begin
          iter_d[j*W +: W] = elem(iter_q, j) + W'(1);
          carry            = 1'b0;
        end
      end
      last_d[j]     = (elem(iter_d, j) == elem(bounds_q, j) - W'(1));
      start_last[j] = (elem(bus.bounds, j) == W'(1));
      if (elem(bus.bounds, j) == '0) begin
        zero_trip = 1'b1;
      end
    end
  end

  assign final_vec = &last_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bounds_q <= '0;
      iter_q   <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            bounds_q <= bus.bounds;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            if (zero_trip) begin
              state_q <= S_DONE;
              last_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              last_q  <= start_last;
              valid_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            if (final_vec) begin
              // Final vector retires; iter_vec keeps its last value.
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              iter_q <= iter_d;
              last_q <= last_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.iter_vec   = iter_q;
  assign bus.last_flags = last_q;
  assign bus.iter_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_iteration_vector_counter.sv
// Directed bench: a table of per-cycle vectors for two (2,3,1) runs, then hand-written
// sequences for zero-trip, single-vector, max-bound and mid-run reset cases.
module tb_iteration_vector_counter;
  localparam int D  = 3;
  localparam int W  = 8;
  localparam int VW = D * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iteration_vector_counter_if #(.DIMENSION(D), .MATRIX_ELEMENT_WIDTH(W)) bus ();

  iteration_vector_counter #(.DIMENSION(D), .MATRIX_ELEMENT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          start;
    logic          stall;
    logic [0:VW-1] bounds;
    logic [0:VW-1] vec;
    logic [0:D-1]  last;
    logic          valid;
    logic          busy;
    logic          done;
  } row_t;

  row_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [0:VW-1] v3(input int a, input int b, input int c);
    logic [7:0] a8, b8, c8;
    a8 = a[7:0];
    b8 = b[7:0];
    c8 = c[7:0];
    return {a8, b8, c8};
  endfunction

  function automatic row_t mk(input logic s, input logic st, input logic [0:VW-1] b,
                              input logic [0:VW-1] v, input logic [0:D-1] l,
                              input logic va, input logic bu, input logic dn);
    row_t r;
    r.start = s;  r.stall = st; r.bounds = b; r.vec = v; r.last = l;
    r.valid = va; r.busy = bu;  r.done = dn;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:VW-1] b231, b999;
    int nv, bad, c;
    logic seen_done;
    logic [0:D-1] last_at_end;

    b231 = v3(2, 3, 1);
    b999 = v3(9, 9, 9);

    // Run 1: plain (2,3,1); run 2: stall on RUN cycles 3-4, bounds wiggled, start in RUN/DONE.
    tbl.push_back(mk(1, 0, b231, v3(0, 0, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 0, 0), 3'b101, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(0, 1, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 1, 0), 3'b101, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(0, 2, 0), 3'b011, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 2, 0), 3'b111, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 2, 0), 3'b000, 0, 1, 1));
    tbl.push_back(mk(0, 0, b231, v3(1, 2, 0), 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 0, b231, v3(0, 0, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 0, 0), 3'b101, 1, 1, 0));
    tbl.push_back(mk(0, 0, b999, v3(0, 1, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 1, b999, v3(0, 1, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 1, b231, v3(0, 1, 0), 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 1, 0), 3'b101, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(0, 2, 0), 3'b011, 1, 1, 0));
    tbl.push_back(mk(0, 0, b231, v3(1, 2, 0), 3'b111, 1, 1, 0));
    tbl.push_back(mk(1, 0, b231, v3(1, 2, 0), 3'b000, 0, 1, 1));
    tbl.push_back(mk(1, 0, b231, v3(1, 2, 0), 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 1, b231, v3(1, 2, 0), 3'b000, 0, 0, 0));

    rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; bus.bounds = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_vec",   bus.iter_vec,   '0);
    check("reset_last",  bus.last_flags, '0);
    check("reset_valid", bus.iter_valid, 1'b0);
    check("reset_busy",  bus.busy,       1'b0);
    check("reset_done",  bus.done,       1'b0);

    foreach (tbl[i]) begin
      bus.start  = tbl[i].start;
      bus.stall  = tbl[i].stall;
      bus.bounds = tbl[i].bounds;
      step();
      check($sformatf("row%0d_vec", i),   bus.iter_vec,   tbl[i].vec);
      check($sformatf("row%0d_valid", i), bus.iter_valid, tbl[i].valid);
      check($sformatf("row%0d_busy", i),  bus.busy,       tbl[i].busy);
      check($sformatf("row%0d_done", i),  bus.done,       tbl[i].done);
      if (tbl[i].valid) check($sformatf("row%0d_last", i), bus.last_flags, tbl[i].last);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;

    // Zero-trip nest (4,0,5): straight to DONE, never valid.
    bus.bounds = v3(4, 0, 5);
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    check("zt_valid", bus.iter_valid, 1'b0);
    check("zt_busy",  bus.busy,       1'b1);
    check("zt_done",  bus.done,       1'b1);
    step();
    check("zt_idle_busy",  bus.busy,       1'b0);
    check("zt_idle_done",  bus.done,       1'b0);
    check("zt_idle_valid", bus.iter_valid, 1'b0);

    // Single vector (1,1,1); start with new bounds during RUN is ignored.
    bus.bounds = v3(1, 1, 1);
    bus.start  = 1'b1;
    step();
    check("one_vec",   bus.iter_vec,   v3(0, 0, 0));
    check("one_last",  bus.last_flags, 3'b111);
    check("one_valid", bus.iter_valid, 1'b1);
    bus.bounds = b999;
    step();
    bus.start = 1'b0;
    check("one_done",       bus.done,       1'b1);
    check("one_done_valid", bus.iter_valid, 1'b0);
    step();
    check("one_idle_busy",  bus.busy,       1'b0);
    check("one_idle_valid", bus.iter_valid, 1'b0);
    step();
    check("one_no_rerun",   bus.iter_valid, 1'b0);

    // Max trip count (255,1,1): element 0 counts 0..254 without wrapping.
    bus.bounds = v3(255, 1, 1);
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    nv = 0; bad = 0; seen_done = 1'b0; last_at_end = '0;
    for (c = 0; c < 400; c++) begin
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.iter_valid) begin
        if (bus.iter_vec[0:7] != nv[7:0]) bad++;
        last_at_end = bus.last_flags;
        nv++;
      end
      step();
    end
    check("max_seq_errors", bad, 0);
    check("max_count",      nv,  255);
    check("max_done_seen",  seen_done, 1'b1);
    check("max_final_last", last_at_end, 3'b111);
    check("max_final_e0",   bus.iter_vec[0:7], 8'd254);
    step();

    // Reset on the 3rd vector of a (2,3,1) run, then a fresh run replays from zero.
    bus.bounds = b231;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("rst_pre_vec", bus.iter_vec, v3(0, 1, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_vec",   bus.iter_vec,   '0);
    check("rst_last",  bus.last_flags, '0);
    check("rst_valid", bus.iter_valid, 1'b0);
    check("rst_busy",  bus.busy,       1'b0);
    check("rst_done",  bus.done,       1'b0);
    step();
    check("rst_no_done", bus.done, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("rerun_vec",   bus.iter_vec,   v3(0, 0, 0));
    check("rerun_last",  bus.last_flags, 3'b001);
    check("rerun_valid", bus.iter_valid, 1'b1);
    nv = 1; seen_done = 1'b0;
    for (c = 0; c < 20; c++) begin
      step();
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.iter_valid) nv++;
    end
    check("rerun_count",     nv,        6);
    check("rerun_done_seen", seen_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
